// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams LEN operand pairs from a synchronous buffer into a
// registered MAC unit, chains the accumulator and hands the result out on valid/ready.
module mac_seq_ctrl #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [ACC_WIDTH-1:0]  i_bias,
  output logic                  o_busy,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [IN_WIDTH-1:0]   i_rd_a,
  input  logic [IN_WIDTH-1:0]   i_rd_b,
  output logic                  o_mac_en,
  output logic [IN_WIDTH-1:0]   o_mac_a,
  output logic [IN_WIDTH-1:0]   o_mac_b,
  output logic [ACC_WIDTH-1:0]  o_mac_acc_in,
  input  logic [ACC_WIDTH-1:0]  i_mac_acc_out,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ACC_WIDTH-1:0]  o_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  state_e                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ACC_WIDTH-1:0]  r_bias;
  logic                  r_busy;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_mac_en;
  logic                  r_first;
  logic                  r_zero;
  logic                  r_out_valid;

  logic [LEN_WIDTH-1:0]  w_len_clamp;
  logic                  w_last;
  logic                  w_zero_start;

  assign w_len_clamp  = (i_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : i_len;
  assign w_last       = (LEN_WIDTH'(r_rd_addr) == (r_len - LEN_WIDTH'(1)));
  assign w_zero_start = (r_state == StIdle) && i_start && (w_len_clamp == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_bias      <= '0;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_mac_en    <= 1'b0;
      r_first     <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // MAC issue trails each read by one cycle; a zero-length job issues one bias-only term.
      r_mac_en <= r_rd_en | w_zero_start;
      if (r_mac_en) begin
        r_first <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_len   <= w_len_clamp;
            r_bias  <= i_bias;
            r_busy  <= 1'b1;
            r_first <= 1'b1;
            r_zero  <= (w_len_clamp == '0);
            if (w_len_clamp != '0) begin
              r_state   <= StRun;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end else begin
              r_state <= StDrain;
            end
          end
        end
        StRun: begin
          if (w_last) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= StDrain;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          r_state     <= StOut;
          r_out_valid <= 1'b1;
        end
        StOut: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_mac_en  = r_mac_en;

  // Buffer data is only valid in the issue cycle, so operands pass straight through, gated.
  assign o_mac_a      = (r_mac_en && !r_zero) ? i_rd_a : '0;
  assign o_mac_b      = (r_mac_en && !r_zero) ? i_rd_b : '0;
  assign o_mac_acc_in = !r_mac_en ? '0 : (r_first ? r_bias : i_mac_acc_out);

  assign o_out_valid = r_out_valid;
  assign o_result    = r_out_valid ? i_mac_acc_out : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural operand buffer and registered MAC unit.
module tb_mac_seq_ctrl;

  localparam int unsigned IW = 8;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    len;
  logic [AW-1:0] bias;
  logic          busy;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [IW-1:0] rd_a;
  logic [IW-1:0] rd_b;
  logic          mac_en;
  logic [IW-1:0] mac_a;
  logic [IW-1:0] mac_b;
  logic [AW-1:0] mac_acc_in;
  logic [AW-1:0] mac_acc_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .IN_WIDTH  (8),
    .ACC_WIDTH (16),
    .MAX_LEN   (16),
    .ADDR_WIDTH(4),
    .LEN_WIDTH (5)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_len        (len),
    .i_bias       (bias),
    .o_busy       (busy),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_a       (rd_a),
    .i_rd_b       (rd_b),
    .o_mac_en     (mac_en),
    .o_mac_a      (mac_a),
    .o_mac_b      (mac_b),
    .o_mac_acc_in (mac_acc_in),
    .i_mac_acc_out(mac_acc_out),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_result     (result)
  );

  logic [IW-1:0] mem_a [16];
  logic [IW-1:0] mem_b [16];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) mac_acc_out <= '0;
    else if (mac_en) mac_acc_out <= mac_acc_in + AW'(mac_a) * AW'(mac_b);
  end

  int rd_count, mac_count, addr_err, hs_count;

  always @(posedge clk) begin
    if (rd_en) begin
      if (int'(rd_addr) != rd_count) addr_err++;
      rd_count++;
    end
    if (mac_en) mac_count++;
    if (out_valid && out_ready) hs_count++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [4:0]      len;
    logic [AW-1:0]   bias;
    logic [15:0][7:0] a;
    logic [15:0][7:0] b;
    logic [AW-1:0]   exp_res;
    int              exp_lat;
    int              exp_reads;
  } vec_t;

  vec_t tbl [5];

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = v.a[i];
      mem_b[i] = v.b[i];
    end
  endtask

  // Starts a job at the next edge and returns latency (-1 on timeout) observed at negedges.
  task automatic kick(input vec_t v, output int lat);
    @(negedge clk);
    load(v);
    rd_count = 0; mac_count = 0; addr_err = 0;
    len = v.len; bias = v.bias; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_job(input vec_t v);
    int lat;
    out_ready = 1'b1;
    kick(v, lat);
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " result"}, 32'(result), 32'(v.exp_res));
    @(negedge clk);
    check({v.name, " valid after hs"}, 32'(out_valid), 0);
    check({v.name, " busy after hs"}, 32'(busy), 0);
    check({v.name, " reads"}, rd_count, v.exp_reads);
    check({v.name, " mac_en cycles"}, mac_count, (v.exp_reads == 0) ? 1 : v.exp_reads);
    check({v.name, " addr order"}, addr_err, 0);
  endtask

  initial begin
    vec_t v;
    int   lat, vc, rc, hs_base;

    for (int t = 0; t < 5; t++) begin
      tbl[t].a = '0;
      tbl[t].b = '0;
    end
    tbl[0].name = "basic"; tbl[0].len = 5'd3; tbl[0].bias = 16'd10;
    tbl[0].a[0] = 8'd1; tbl[0].a[1] = 8'd2; tbl[0].a[2] = 8'd3;
    tbl[0].b[0] = 8'd4; tbl[0].b[1] = 8'd5; tbl[0].b[2] = 8'd6;
    tbl[0].exp_res = 16'd42; tbl[0].exp_lat = 5; tbl[0].exp_reads = 3;

    tbl[1].name = "wrap"; tbl[1].len = 5'd2; tbl[1].bias = 16'hFFFF;
    tbl[1].a[0] = 8'd255; tbl[1].a[1] = 8'd255; tbl[1].b[0] = 8'd255; tbl[1].b[1] = 8'd255;
    tbl[1].exp_res = 16'hFC01; tbl[1].exp_lat = 4; tbl[1].exp_reads = 2;

    tbl[2].name = "len0"; tbl[2].len = 5'd0; tbl[2].bias = 16'h1234;
    tbl[2].a[0] = 8'd9; tbl[2].b[0] = 8'd9;
    tbl[2].exp_res = 16'h1234; tbl[2].exp_lat = 2; tbl[2].exp_reads = 0;

    // len=20 clamps to 16 terms: sum of 1..16 = 136
    tbl[3].name = "len20"; tbl[3].len = 5'd20; tbl[3].bias = 16'd0;
    for (int i = 0; i < 16; i++) begin
      tbl[3].a[i] = 8'(i + 1);
      tbl[3].b[i] = 8'd1;
    end
    tbl[3].exp_res = 16'd136; tbl[3].exp_lat = 18; tbl[3].exp_reads = 16;

    // 5 + 2*(0+1+..+15) = 245
    tbl[4].name = "len16"; tbl[4].len = 5'd16; tbl[4].bias = 16'd5;
    for (int i = 0; i < 16; i++) begin
      tbl[4].a[i] = 8'(i);
      tbl[4].b[i] = 8'd2;
    end
    tbl[4].exp_res = 16'd245; tbl[4].exp_lat = 18; tbl[4].exp_reads = 16;

    rst = 1'b1; start = 1'b1; len = 5'd3; bias = 16'd7; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset rd_en", 32'(rd_en), 0);
    check("reset mac_en", 32'(mac_en), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset result", 32'(result), 0);
    rst = 1'b0; start = 1'b0;

    for (int t = 0; t < 5; t++) run_job(tbl[t]);

    // Backpressure: result must hold while out_ready is low; start during OUT is ignored.
    out_ready = 1'b0;
    kick(tbl[0], lat);
    check("bp latency", lat, 5);
    hs_base = hs_count;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      check("bp valid held", 32'(out_valid), 1);
      check("bp result held", 32'(result), 42);
      if (j == 1) begin
        start = 1'b1; len = 5'd1; bias = 16'd0;
      end
      if (j == 2) start = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp valid after hs", 32'(out_valid), 0);
    check("bp busy after hs", 32'(busy), 0);
    vc = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (out_valid || busy) vc++;
    end
    check("bp start ignored", vc, 0);
    check("bp single hs", hs_count - hs_base, 1);

    // Reset during RUN term k=2 of a len=8 job.
    v = tbl[3];
    v.len = 5'd8;
    @(negedge clk);
    load(v);
    len = v.len; bias = 16'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun rd_addr", 32'(rd_addr), 2);
    check("midrun rd_en", 32'(rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun rst rd_en", 32'(rd_en), 0);
    check("midrun rst mac_en", 32'(mac_en), 0);
    check("midrun rst busy", 32'(busy), 0);
    vc = 0; rc = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (out_valid) vc++;
      if (rd_en || mac_en) rc++;
    end
    check("midrun no valid", vc, 0);
    check("midrun no activity", rc, 0);

    v.name = "post-reset"; v.len = 5'd1; v.bias = 16'd1;
    v.a = '0; v.b = '0;
    v.a[0] = 8'd3; v.b[0] = 8'd7;
    v.exp_res = 16'd22; v.exp_lat = 3; v.exp_reads = 1;
    run_job(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that drives one mac_unit through a LEN-term dot product (bias + sum of a[i]*b[i]). It fetches operand pairs from a synchronous operand buffer, chains the MAC accumulator, and presents the result on a valid/ready output port. It sits between the layer controller (start/len/bias) and the MAC datapath. The MAC's own en/a/b/acc_in are driven only by this block.

Parameters:
IN_WIDTH, 8, operand width (matches mac_unit IN_WIDTH)
ACC_WIDTH, 16, accumulator/result width (matches mac_unit ACC_WIDTH)
MAX_LEN, 16, maximum terms per dot product
ADDR_WIDTH, 4, operand buffer address width, $clog2(MAX_LEN)
LEN_WIDTH, 5, width of len, $clog2(MAX_LEN+1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset (also tied to mac_unit rst)
start  in  1  request new dot product; sampled only in IDLE
len  in  LEN_WIDTH  term count, latched with start
bias  in  ACC_WIDTH  initial accumulator value, latched with start
busy  out  1  high in every state except IDLE
rd_en  out  1  operand buffer read strobe
rd_addr  out  ADDR_WIDTH  operand buffer address
rd_a  in  IN_WIDTH  operand a, valid the cycle after rd_en
rd_b  in  IN_WIDTH  operand b, valid the cycle after rd_en
mac_en  out  1  to mac_unit en
mac_a  out  IN_WIDTH  to mac_unit a
mac_b  out  IN_WIDTH  to mac_unit b
mac_acc_in  out  ACC_WIDTH  to mac_unit acc_in
mac_acc_out  in  ACC_WIDTH  from mac_unit acc_out
out_valid  out  1  result valid
out_ready  in  1  downstream accept
result  out  ACC_WIDTH  dot product result

Behaviour:
- States: IDLE, RUN, DRAIN, OUT. Reset: state IDLE; busy, rd_en, rd_addr, mac_en, mac_a, mac_b, mac_acc_in, out_valid, result all 0. Internal term counter and first-term flag are cleared.
- IDLE: when start=1, latch len (values > MAX_LEN clamp to MAX_LEN) and bias. Go to RUN if len>0, otherwise go to DRAIN.
- RUN: one read per cycle. In RUN cycle k (k=0..len-1): rd_en=1, rd_addr=k. After k=len-1, go to DRAIN.
- Issue pipeline: a registered flag follows rd_en by 1 cycle. mac_en=1 in the cycle after each read, with mac_a=rd_a and mac_b=rd_b.
- Accumulator chaining: mac_acc_in=bias for the first term and mac_acc_out for every later term. The MAC is registered, so back-to-back terms chain with no bubble.
- DRAIN (1 cycle): carries mac_en for the last term. When len=0, DRAIN instead drives mac_en=1, mac_a=0, mac_b=0, mac_acc_in=bias, so the result equals bias. Next state is OUT.
- OUT: out_valid=1 and result=mac_acc_out. mac_en=0, so the MAC holds and result stays stable. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: start sampled at edge E0 -> out_valid high from edge E0+len+2 (len=0: E0+2).
- Throughput: a new start is accepted at the earliest in the cycle after the handshake.
- Arithmetic: unsigned, modulo 2^ACC_WIDTH wrap. No saturation, no overflow flag.
- start while busy is ignored; len and bias are not re-latched.
- out_ready high outside OUT has no effect. out_valid is never withdrawn without a handshake, except on reset.
- rst mid-operation (any state): next cycle is IDLE with all outputs 0. A pending result is discarded and no partial read or MAC enable is issued afterward.
- rd_addr never exceeds len-1. rd_en=0 outside RUN.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, rd_en=0, mac_en=0, out_valid=0, result=0.
- Basic: len=3, bias=10, buffer a={1,2,3}, b={4,5,6}, out_ready=1 -> rd_addr 0,1,2 on consecutive cycles; mac_en high 3 consecutive cycles; out_valid at E0+5; result=42; busy low the cycle after the handshake.
- Backpressure: same job, out_ready=0 for 4 cycles, start pulsed during OUT -> result stays 42 and out_valid stays 1 throughout; start ignored; single handshake when out_ready rises.
- Overflow/wrap: len=2, bias=16'hFFFF, a={255,255}, b={255,255} -> result=16'hFC01.
- Boundary lengths: len=0, bias=16'h1234 -> out_valid at E0+2, result=16'h1234, rd_en never high. len=20 (MAX_LEN=16) -> exactly 16 reads, addresses 0..15, out_valid at E0+18.
- Reset mid-RUN: assert rst during RUN cycle k=2 of a len=8 job -> next cycle IDLE, rd_en=0, mac_en=0, busy=0, out_valid never asserted. A following len=1 job with a=3, b=7, bias=1 gives result=22.
